// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - zero-fill then round-robin share of a simple-dual-port RAM between two requesters
module ram_port_arbiter #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_we,
  input  logic [A_WIDTH-1:0] req0_addr,
  input  logic [D_WIDTH-1:0] req0_wdata,
  output logic               rsp0_valid,
  output logic [D_WIDTH-1:0] rsp0_rdata,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_we,
  input  logic [A_WIDTH-1:0] req1_addr,
  input  logic [D_WIDTH-1:0] req1_wdata,
  output logic               rsp1_valid,
  output logic [D_WIDTH-1:0] rsp1_rdata,

  output logic [A_WIDTH-1:0] ram_address_write,
  output logic [D_WIDTH-1:0] ram_data_write,
  output logic               ram_write_enable,
  output logic [A_WIDTH-1:0] ram_address_read,
  input  logic [D_WIDTH-1:0] ram_data_read,

  output logic               init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic               init_done_q;
  // 0: requester 0 wins the next contention, 1: requester 1 wins
  logic               rr_prio_q;
  logic [1:0]         pend_q;
  logic [A_WIDTH-1:0] rd_addr_q;

  logic               grant0, grant1, any_grant;
  logic               sel_we;
  logic [A_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_wdata;
  logic               read_grant;

  // Next-state logic: walk every address once in INIT, then stay in RUN
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Arbitration: a lone requester always wins, contention goes to the priority holder
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_RUN) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~rr_prio_q;
        grant1 = rr_prio_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Command mux: pick the fields of whichever requester was granted
  always_comb begin
    any_grant  = grant0 | grant1;
    sel_we     = grant1 ? req1_we    : req0_we;
    sel_addr   = grant1 ? req1_addr  : req0_addr;
    sel_wdata  = grant1 ? req1_wdata : req0_wdata;
    read_grant = any_grant & ~sel_we;
  end

  // RAM port drive: zero-fill during INIT, granted command during RUN; read address holds when idle
  always_comb begin
    ram_write_enable  = 1'b0;
    ram_address_write = '0;
    ram_data_write    = '0;
    ram_address_read  = rd_addr_q;
    if (state_q == ST_INIT) begin
      ram_write_enable  = 1'b1;
      ram_address_write = init_cnt_q;
    end else if (any_grant) begin
      if (sel_we) begin
        ram_write_enable  = 1'b1;
        ram_address_write = sel_addr;
        ram_data_write    = sel_wdata;
      end else begin
        ram_address_read  = sel_addr;
      end
    end
  end

  // State registers; reset drops any in-flight read and restarts the zero-fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rr_prio_q   <= 1'b0;
      pend_q      <= 2'b00;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= (state_d == ST_RUN);
      if (any_grant) begin
        rr_prio_q <= grant0;
      end
      pend_q <= {grant1 & read_grant, grant0 & read_grant};
      if (read_grant) begin
        rd_addr_q <= sel_addr;
      end
    end
  end

  // Handshake and response outputs; read data is forced to zero outside its valid cycle
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp0_valid = pend_q[0];
    rsp1_valid = pend_q[1];
    rsp0_rdata = pend_q[0] ? ram_data_read : '0;
    rsp1_rdata = pend_q[1] ? ram_data_read : '0;
    init_done  = init_done_q;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed and randomized checks of ram_port_arbiter against a behavioural model
module tb_ram_port_arbiter;
  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] ram_address_write, ram_address_read;
  logic [DW-1:0] ram_data_write, ram_data_read;
  logic          ram_write_enable, init_done;

  always #5 clk = ~clk;

  ram_port_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_address_write(ram_address_write), .ram_data_write(ram_data_write),
    .ram_write_enable(ram_write_enable), .ram_address_read(ram_address_read),
    .ram_data_read(ram_data_read), .init_done(init_done)
  );

  // Simple-dual-port RAM with registered read, preloaded with junk so the zero-fill is observable
  logic [DW-1:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
  end
  always @(posedge clk) begin
    if (ram_write_enable) ram[ram_address_write] <= ram_data_write;
    ram_data_read <= ram[ram_address_read];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents of memory, init progress, last winner, outstanding reads
  bit            m_run;
  int            m_cnt;
  int            m_last;
  bit            m_pend [2];
  logic [DW-1:0] m_pd   [2];
  logic [AW-1:0] m_raddr;
  logic [DW-1:0] shadow [DEPTH];

  always @(negedge clk) begin : model
    int            g;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!rst_n) begin
      m_run = 0; m_cnt = 0; m_last = 1;
      m_pend[0] = 0; m_pend[1] = 0; m_raddr = '0;
    end
    chk("m_init_done", {31'd0, init_done}, {31'd0, m_run});
    chk("m_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_pend[0]});
    chk("m_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_pend[1]});
    chk("m_rsp0_rdata", {16'd0, rsp0_rdata}, {16'd0, m_pend[0] ? m_pd[0] : 16'h0});
    chk("m_rsp1_rdata", {16'd0, rsp1_rdata}, {16'd0, m_pend[1] ? m_pd[1] : 16'h0});
    g = -1; w = 0; a = '0; d = '0;
    if (!m_run) begin
      chk("m_ready0", {31'd0, req0_ready}, 32'd0);
      chk("m_ready1", {31'd0, req1_ready}, 32'd0);
      chk("m_init_we", {31'd0, ram_write_enable}, 32'd1);
      chk("m_init_waddr", {27'd0, ram_address_write}, 32'(m_cnt));
      chk("m_init_wdata", {16'd0, ram_data_write}, 32'd0);
      chk("m_raddr_hold", {27'd0, ram_address_read}, {27'd0, m_raddr});
    end else begin
      if (req0_valid && req1_valid) g = 1 - m_last;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
      if (g == 0) begin w = req0_we; a = req0_addr; d = req0_wdata; end
      if (g == 1) begin w = req1_we; a = req1_addr; d = req1_wdata; end
      chk("m_ready0", {31'd0, req0_ready}, {31'd0, g == 0});
      chk("m_ready1", {31'd0, req1_ready}, {31'd0, g == 1});
      chk("m_we", {31'd0, ram_write_enable}, {31'd0, (g >= 0) && w});
      if ((g >= 0) && w) begin
        chk("m_waddr", {27'd0, ram_address_write}, {27'd0, a});
        chk("m_wdata", {16'd0, ram_data_write}, {16'd0, d});
      end
      chk("m_raddr", {27'd0, ram_address_read}, {27'd0, ((g >= 0) && !w) ? a : m_raddr});
    end
    if (rst_n) begin
      m_pend[0] = 0; m_pend[1] = 0;
      if (!m_run) begin
        shadow[m_cnt] = '0;
        if (m_cnt == DEPTH - 1) m_run = 1;
        m_cnt++;
      end else if (g >= 0) begin
        m_last = g;
        if (w) shadow[a] = d;
        else begin
          m_raddr = a;
          m_pend[g] = 1;
          m_pd[g] = shadow[a];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input bit v, input bit we, input int a, input int d);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_addr = AW'(a); req0_wdata = DW'(d);
    end else begin
      req1_valid = v; req1_we = we; req1_addr = AW'(a); req1_wdata = DW'(d);
    end
  endtask

  task automatic single_op(input int n, input bit we, input int a, input int d);
    drive(n, 1, we, a, d);
    @(negedge clk);
    chk("op_ready", {31'd0, (n == 0) ? req0_ready : req1_ready}, 32'd1);
    tick();
    drive(n, 0, 0, 0, 0);
  endtask

  task automatic read_expect(input int n, input int a, input int exp);
    single_op(n, 0, a, 0);
    @(negedge clk);
    chk("rd_valid", {31'd0, (n == 0) ? rsp0_valid : rsp1_valid}, 32'd1);
    chk("rd_data", {16'd0, (n == 0) ? rsp0_rdata : rsp1_rdata}, 32'(exp));
    chk("rd_other_quiet", {31'd0, (n == 0) ? rsp1_valid : rsp0_valid}, 32'd0);
    tick();
  endtask

  task automatic wait_init();
    int cnt;
    rst_n = 1'b1;
    cnt = 0;
    while (!init_done && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("init_cycles", 32'(cnt), 32'd32);
  endtask

  initial begin
    int hold;
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    chk("rst_we", {31'd0, ram_write_enable}, 32'd1);
    chk("rst_waddr", {27'd0, ram_address_write}, 32'd0);
    chk("rst_raddr", {27'd0, ram_address_read}, 32'd0);
    tick();
    wait_init();
    read_expect(0, 0, 0);
    read_expect(0, 17, 0);
    read_expect(0, 31, 0);

    // write then read-after-write on the following cycle
    drive(0, 1, 1, 3, 16'hBEEF);
    @(negedge clk); chk("raw_wr_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    drive(0, 1, 0, 3, 0);
    @(negedge clk); chk("raw_rd_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("raw_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("raw_data", {16'd0, rsp0_rdata}, 32'hBEEF);
    chk("raw_rsp1_quiet", {31'd0, rsp1_valid}, 32'd0);
    tick();

    // continuous contention alternates 0,1,0,1
    single_op(0, 1, 1, 16'h1111);
    single_op(1, 1, 2, 16'h2222);
    drive(0, 1, 0, 1, 0);
    drive(1, 1, 0, 2, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_ready0", {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
      chk("rr_ready1", {31'd0, req1_ready}, {31'd0, (i % 2) == 1});
      if (i > 0) begin
        chk("rr_rsp0", {15'd0, rsp0_valid, rsp0_rdata}, ((i % 2) == 1) ? 32'h11111 : 32'h0);
        chk("rr_rsp1", {15'd0, rsp1_valid, rsp1_rdata}, ((i % 2) == 0) ? 32'h12222 : 32'h0);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("rr_last_rsp1", {15'd0, rsp1_valid, rsp1_rdata}, 32'h12222);
    tick();

    // lone requester gets back-to-back grants and in-order responses
    single_op(0, 1, 5, 16'h0005);
    single_op(0, 1, 6, 16'h0006);
    drive(1, 1, 0, 5, 0);
    @(negedge clk); chk("b2b_ready_a", {31'd0, req1_ready}, 32'd1);
    tick();
    drive(1, 1, 0, 6, 0);
    @(negedge clk);
    chk("b2b_ready_b", {31'd0, req1_ready}, 32'd1);
    chk("b2b_rsp_a", {15'd0, rsp1_valid, rsp1_rdata}, 32'h10005);
    tick();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_rsp_b", {15'd0, rsp1_valid, rsp1_rdata}, 32'h10006);
    tick();

    // simultaneous write (req0) and read (req1) of the same address
    drive(0, 1, 1, 7, 16'hA5A5);
    drive(1, 1, 0, 7, 0);
    @(negedge clk);
    chk("wr_first", {30'd0, req0_ready, req1_ready}, 32'b10);
    tick();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd_second", {30'd0, req0_ready, req1_ready}, 32'b01);
    tick();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("wr_rd_data", {15'd0, rsp1_valid, rsp1_rdata}, 32'h1A5A5);
    tick();

    // reset right after a read handshake drops the response and re-zeroes memory
    drive(0, 1, 0, 7, 0);
    @(negedge clk); chk("rst_rd_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_drop_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    tick(); tick();
    wait_init();
    read_expect(0, 7, 0);

    // randomized traffic with occasional resets
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 699) == 0) begin
        rst_n = 1'b0;
        hold = $urandom_range(1, 3);
      end
      drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom);
      drive(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom);
      tick();
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
